// File: rtl/proto_matrix_scheduler_pkg.sv
// Shared types for the proto-matrix layer scheduler.
//   state_t   : scheduler FSM states
//   cmd_t     : one block command (row, col, shift, last, iter); fields are
//               FIELD_W wide and the top truncates to its own parameters
//   skip_code : all-ones ROM code of a given shift width (zero block marker)
package proto_matrix_scheduler_pkg;

  localparam int FIELD_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FLUSH  = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef struct packed {
    logic [FIELD_W-1:0] row;
    logic [FIELD_W-1:0] col;
    logic [FIELD_W-1:0] shift;
    logic               last;
    logic [FIELD_W-1:0] iter;
  } cmd_t;

  // All-ones in the low 'width' bits, zero above.
  function automatic logic [FIELD_W-1:0] skip_code(input int unsigned width);
    logic [FIELD_W-1:0] v;
    v = '0;
    for (int i = 0; i < FIELD_W; i++) begin
      if (i < int'(width)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/proto_cmd_reg.sv
// One-entry registered command output stage.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : synchronous flush (drops valid, zeroes payload)
//   load_i     : capture cmd_i; only asserted when the stage is free
//   ready_i    : downstream ready
//   valid_o    : command valid
//   cmd_o      : registered command payload
// Handshake: a transfer happens on a rising edge where valid_o & ready_i are
// both 1. Once valid_o rises, valid_o and cmd_o hold until that transfer; the
// producer only loads when !valid_o | ready_i.
module proto_cmd_reg
  import proto_matrix_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic load_i,
  input  logic ready_i,
  input  cmd_t cmd_i,
  output logic valid_o,
  output cmd_t cmd_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      cmd_o   <= '0;
    end else if (clear_i) begin
      valid_o <= 1'b0;
      cmd_o   <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      cmd_o   <= cmd_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/proto_matrix_scheduler.sv
// Layered-decoder schedule generator: walks an external proto-matrix ROM in
// row-major order and emits one command per non-skip block, flagging the
// final block of each layer, for num_iter iterations.
//   clk, rst_n      : clock, async active-low reset
//   start, num_iter : begin a schedule (num_iter 0 treated as 1)
//   abort           : synchronous cancel, wins over start
//   rom_addr/rom_data : combinational ROM lookup, addr = row*COLS+col
//   cmd_*           : valid/ready command stream (see proto_cmd_reg)
//   busy, done      : schedule in progress / one-cycle completion pulse
module proto_matrix_scheduler
  import proto_matrix_scheduler_pkg::*;
#(
  parameter int Z     = 54,
  parameter int WIDTH = 6,
  parameter int ROWS  = 4,
  parameter int COLS  = 24,
  parameter int ADDRW = 7,
  parameter int ITERW = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ITERW-1:0]         num_iter,
  input  logic                     abort,
  output logic [ADDRW-1:0]         rom_addr,
  input  logic [WIDTH-1:0]         rom_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [$clog2(ROWS)-1:0]  cmd_row,
  output logic [$clog2(COLS)-1:0]  cmd_col,
  output logic [WIDTH-1:0]         cmd_shift,
  output logic                     cmd_last,
  output logic [ITERW-1:0]         cmd_iter,
  output logic                     busy,
  output logic                     done
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [FIELD_W-1:0] SKIP = skip_code(WIDTH);
  localparam logic Z_LEGAL = (Z == 27) || (Z == 54) || (Z == 81);

  state_t           state_q;
  logic [RW-1:0]    row_q;
  logic [CW-1:0]    col_q;
  logic [ITERW-1:0] iter_q, last_iter_q;
  logic             pend_valid_q;
  cmd_t             pend_q;
  logic             busy_q, done_q;

  cmd_t cur_cmd, load_cmd, cmd_out;
  logic cur_nonskip, at_last_col, out_free;
  logic emit_pend, emit_cur, capture, load, stall;

  assign rom_addr = (state_q == SCAN) ? ADDRW'(32'(row_q) * 32'(COLS) + 32'(col_q)) : '0;

  always_comb begin
    cur_nonskip    = (FIELD_W'(rom_data) != SKIP);
    at_last_col    = (col_q == COL_LAST);
    out_free       = !cmd_valid || cmd_ready;
    cur_cmd.row    = FIELD_W'(row_q);
    cur_cmd.col    = FIELD_W'(col_q);
    cur_cmd.shift  = FIELD_W'(rom_data);
    cur_cmd.last   = at_last_col;
    cur_cmd.iter   = FIELD_W'(iter_q);
    emit_pend = 1'b0;
    emit_cur  = 1'b0;
    capture   = 1'b0;
    load      = 1'b0;
    stall     = 1'b0;
    load_cmd  = pend_q;
    if (state_q == SCAN) begin
      // pend_q.last marks a pending entry that closed the previous row; it
      // goes out as soon as possible. A same-row pending entry waits for the
      // next non-skip block, or for the row end to learn that it is final.
      emit_pend = pend_valid_q && (pend_q.last || cur_nonskip || at_last_col);
      // Row-final block with nothing pending skips the pending register.
      emit_cur  = at_last_col && cur_nonskip && !pend_valid_q;
      capture   = cur_nonskip && !emit_cur;
      if (emit_pend) begin
        load_cmd.last = pend_q.last || (at_last_col && !cur_nonskip);
      end else if (emit_cur) begin
        load_cmd = cur_cmd;
      end
      stall = (emit_pend || emit_cur) && !out_free;
      load  = (emit_pend || emit_cur) && out_free;
    end else if (state_q == FLUSH) begin
      load = pend_valid_q && out_free;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      iter_q       <= '0;
      last_iter_q  <= '0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (abort) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      iter_q       <= '0;
      last_iter_q  <= '0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q      <= SCAN;
            busy_q       <= 1'b1;
            row_q        <= '0;
            col_q        <= '0;
            iter_q       <= '0;
            last_iter_q  <= (num_iter == '0) ? '0 : num_iter - 1'b1;
            pend_valid_q <= 1'b0;
          end
        end
        SCAN: begin
          if (!stall) begin
            if (capture) begin
              pend_q       <= cur_cmd;
              pend_valid_q <= 1'b1;
            end else if (load) begin
              pend_valid_q <= 1'b0;
            end
            if (at_last_col) begin
              col_q <= '0;
              if (row_q == ROW_LAST) begin
                row_q <= '0;
                if (iter_q == last_iter_q) state_q <= FLUSH;
                else iter_q <= iter_q + 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          // Leave only once nothing is pending and the output is draining.
          if (load) begin
            pend_valid_q <= 1'b0;
          end else if (!pend_valid_q && out_free) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  proto_cmd_reg u_cmd_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (abort),
    .load_i  (load),
    .ready_i (cmd_ready),
    .cmd_i   (load_cmd),
    .valid_o (cmd_valid),
    .cmd_o   (cmd_out)
  );

  assign cmd_row   = cmd_out.row[RW-1:0];
  assign cmd_col   = cmd_out.col[CW-1:0];
  assign cmd_shift = cmd_out.shift[WIDTH-1:0];
  assign cmd_last  = cmd_out.last;
  assign cmd_iter  = cmd_out.iter[ITERW-1:0];
  assign busy      = busy_q;
  assign done      = done_q;

  // Upper struct bits are always zero at these parameter sizes.
  logic unused_ok;
  assign unused_ok = ^{cmd_out.row[FIELD_W-1:RW], cmd_out.col[FIELD_W-1:CW],
                       cmd_out.shift[FIELD_W-1:WIDTH], cmd_out.iter[FIELD_W-1:ITERW],
                       Z_LEGAL};

endmodule

// File: tb/tb_proto_matrix_scheduler.sv
// Self-checking bench for proto_matrix_scheduler with a behavioural ROM and
// a scoreboard of expected commands.
module tb_proto_matrix_scheduler;

  localparam int Z     = 54;
  localparam int WIDTH = 6;
  localparam int ROWS  = 4;
  localparam int COLS  = 24;
  localparam int ADDRW = 7;
  localparam int ITERW = 4;
  localparam logic [5:0] SKIP = 6'h3F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_iter = '0;
  logic       abort = 1'b0;
  logic [6:0] rom_addr;
  logic [5:0] rom_data;
  logic       cmd_valid;
  logic       cmd_ready = 1'b1;
  logic [1:0] cmd_row;
  logic [4:0] cmd_col;
  logic [5:0] cmd_shift;
  logic       cmd_last;
  logic [3:0] cmd_iter;
  logic       busy;
  logic       done;

  logic [5:0]  rom_mem [0:127];
  logic [17:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_c = 0;
  int cyc_cnt = 0;
  bit flush_pend;
  bit stall_prev = 1'b0;
  logic [17:0] held;
  logic [17:0] payload;

  proto_matrix_scheduler #(
    .Z(Z), .WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS), .ADDRW(ADDRW), .ITERW(ITERW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_iter(num_iter), .abort(abort),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_shift(cmd_shift), .cmd_last(cmd_last), .cmd_iter(cmd_iter),
    .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  assign rom_data = rom_mem[rom_addr];
  assign payload  = {cmd_row, cmd_col, cmd_shift, cmd_last, cmd_iter};

  // scoreboard monitor: transfers pop the expected queue, stalls must hold
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt = done_cnt + 1;
        done_c   = cyc_cnt;
      end
      if (stall_prev) begin
        checks++;
        if (cmd_valid !== 1'b1 || payload !== held) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b payload=%h want valid=1 payload=%h",
                   cmd_valid, payload, held);
        end
      end
      if (cmd_valid && cmd_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_seq: got unexpected payload=%h want none", payload);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          if (payload !== e) begin
            errors++;
            $display("FAIL cmd_seq: got %h want %h", payload, e);
          end
        end
      end
      stall_prev = cmd_valid && !cmd_ready;
      held       = payload;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ROM images
  task automatic load_image_a();
    for (int i = 0; i < 128; i++)
      rom_mem[i] = ($urandom_range(0, 99) < 45 || i >= ROWS*COLS) ? SKIP : 6'($urandom_range(0, Z-1));
    rom_mem[0*COLS+5]  = 6'd12;
    rom_mem[0*COLS+23] = 6'd7;
    rom_mem[1*COLS+3]  = 6'd9;
    rom_mem[1*COLS+23] = SKIP;
    rom_mem[3*COLS+10] = 6'd1;
    rom_mem[3*COLS+23] = 6'd20;
  endtask

  task automatic load_image_b();
    for (int i = 0; i < 128; i++) rom_mem[i] = SKIP;
    rom_mem[0*COLS+23] = 6'd33;
    rom_mem[1*COLS+0]  = 6'd0;
    rom_mem[1*COLS+5]  = 6'd53;
    rom_mem[3*COLS+0]  = 6'd17;
    rom_mem[3*COLS+23] = 6'd40;
  endtask

  task automatic load_image_skip();
    for (int i = 0; i < 128; i++) rom_mem[i] = SKIP;
  endtask

  // reference model: non-skip blocks in row-major order, last per row flagged
  task automatic build_exp(input int iters);
    int lastc;
    int cnt;
    logic [17:0] e;
    exp_q.delete();
    for (int it = 0; it < iters; it++) begin
      for (int r = 0; r < ROWS; r++) begin
        lastc = -1;
        for (int c = 0; c < COLS; c++) if (rom_mem[r*COLS+c] != SKIP) lastc = c;
        for (int c = 0; c < COLS; c++) begin
          if (rom_mem[r*COLS+c] != SKIP) begin
            e = {r[1:0], c[4:0], rom_mem[r*COLS+c], (c == lastc), it[3:0]};
            exp_q.push_back(e);
          end
        end
      end
    end
    cnt = 0;
    for (int c = 0; c < COLS; c++) if (rom_mem[(ROWS-1)*COLS+c] != SKIP) cnt++;
    flush_pend = (cnt >= 2) && (rom_mem[(ROWS-1)*COLS+COLS-1] != SKIP);
  endtask

  // driver: one full schedule, optional random ready and a start while busy
  task automatic run_schedule(input int n_iter, input bit rnd, input bit mid_start, input string name);
    int iters;
    int d0;
    int start_c;
    int cyc;
    int exp_lat;
    iters = (n_iter == 0) ? 1 : n_iter;
    build_exp(iters);
    d0 = done_cnt;
    @(posedge clk); #1;
    num_iter  = 4'(n_iter);
    start     = 1'b1;
    cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    start_c = cyc_cnt;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_rise: got %b want 1", name, busy);
    end
    cyc = 0;
    while (done_cnt == d0 && cyc < 5000) begin
      if (rnd) cmd_ready = 1'($urandom_range(0, 1));
      if (mid_start && cyc == 20) begin
        start    = 1'b1;
        num_iter = 4'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start     = 1'b0;
    cmd_ready = 1'b1;
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s timeout: got no done want done within 5000 cycles", name);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_cmds: got %0d left want 0", name, exp_q.size());
    end
    if (!rnd) begin
      exp_lat = ROWS*COLS*iters + 1 + int'(flush_pend);
      checks++;
      if (done_c - start_c != exp_lat) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", name, done_c - start_c, exp_lat);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL %s done_once: got %0d pulses want 1", name, done_cnt - d0);
    end
    checks++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: got busy=%b valid=%b want 0 0", name, busy, cmd_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b busy=%b done=%b want 0 0 0", cmd_valid, busy, done);
    end
    checks++;
    if (rom_addr !== 7'd0 || payload !== 18'd0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h payload=%h want 0 0", rom_addr, payload);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 7'd0) begin
      errors++;
      $display("FAIL idle_hold: got valid=%b busy=%b addr=%h want 0 0 0", cmd_valid, busy, rom_addr);
    end
  endtask

  task automatic test_basic();
    load_image_a();
    run_schedule(1, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_random_ready();
    run_schedule(1, 1'b1, 1'b1, "rand_ready");
    run_schedule(2, 1'b1, 1'b0, "rand_ready2");
  endtask

  task automatic test_skip_row();
    load_image_b();
    run_schedule(1, 1'b0, 1'b0, "skip_row");
    load_image_skip();
    run_schedule(2, 1'b0, 1'b0, "all_skip");
  endtask

  task automatic test_multi_iter();
    load_image_a();
    run_schedule(3, 1'b0, 1'b0, "iter3");
    run_schedule(0, 1'b0, 1'b0, "iter0");
  endtask

  task automatic test_abort();
    int d0;
    int cyc;
    load_image_a();
    build_exp(1);
    d0 = done_cnt;
    @(posedge clk); #1;
    num_iter = 4'd1;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(cmd_valid === 1'b1 && cmd_row === 2'd1) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 500) begin
      errors++;
      $display("FAIL abort_wait: got no row-1 command want one within 500 cycles");
    end
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 7'd0) begin
      errors++;
      $display("FAIL abort_clear: got valid=%b busy=%b addr=%h want 0 0 0", cmd_valid, busy, rom_addr);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got pulses=%0d busy=%b want 0 0", done_cnt - d0, busy);
    end
    exp_q.delete();
    run_schedule(1, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid();
    int d0;
    int cyc;
    load_image_a();
    exp_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    num_iter  = 4'd1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cmd_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL rst_mid_wait: got no command want one within 200 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== 7'd0 || payload !== 18'd0) begin
      errors++;
      $display("FAIL rst_mid_clear: got valid=%b busy=%b done=%b addr=%h payload=%h want all 0",
               cmd_valid, busy, done, rom_addr, payload);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    cmd_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got pulses=%0d busy=%b valid=%b want 0 0 0",
               done_cnt - d0, busy, cmd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_ready();
    test_skip_row();
    test_multi_iter();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proto_matrix_scheduler.md
PROTO_MATRIX_SCHEDULER -- requirements
Module: proto_matrix_scheduler

Interface
REQ-001 Parameters SHALL be: Z, default 54, lifting size (27/54/81 legal); WIDTH, default 6, shift width; ROWS, default 4, proto rows (layers); COLS, default 24, proto columns; ADDRW, default 7, ROM address width; ITERW, default 4, iteration-count width.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a decode schedule when idle.
- num_iter  in  ITERW  iteration count, sampled at start; 0 means 1.
- abort  in  1  synchronous cancel.
- rom_addr  out  ADDRW  address to the proto-matrix ROM (row*COLS+col).
- rom_data  in  WIDTH  ROM shift value, combinational response to rom_addr.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  downstream accepts the command.
- cmd_row  out  clog2(ROWS)  layer index.
- cmd_col  out  clog2(COLS)  block-column index.
- cmd_shift  out  WIDTH  circulant shift.
- cmd_last  out  1  final non-skip block of this layer.
- cmd_iter  out  ITERW  current iteration, 0-based.
- busy  out  1  schedule in progress.
- done  out  1  one-cycle pulse at normal completion.

Function
REQ-003 A ROM entry equal to all-ones (2^WIDTH-1) SHALL be a skip (zero block); skips never produce a command.
REQ-004 FSM states SHALL be IDLE, SCAN, FLUSH, FINISH.
REQ-005 IDLE->SCAN on start; num_iter latched; row, col, iter cleared; busy rises next cycle.
REQ-006 SCAN SHALL present rom_addr=row*COLS+col and evaluate rom_data in the same cycle, advancing one column per cycle unless stalled.
REQ-007 A non-skip entry SHALL be captured into a one-deep pending register (row, col, shift, iter); the previously pending entry is then loaded to the command output with cmd_last=0.
REQ-008 At col=COLS-1, the pending entry, or the current entry if non-skip, SHALL be emitted with cmd_last=1, and the scan moves to the next row at col 0.
REQ-009 A row with no non-skip entries SHALL emit nothing.
REQ-010 The scanner SHALL stall (hold row/col/pending) whenever it must load the command output while cmd_valid=1 and cmd_ready=0.
REQ-011 cmd_* SHALL be registered; once asserted, cmd_valid and the payload SHALL hold stable until the cmd_valid&cmd_ready transfer.
REQ-012 With cmd_ready held high, throughput SHALL be one column scanned per cycle with no bubbles beyond skips.
REQ-013 After row ROWS-1, col COLS-1: iter increments and row returns to 0. After the last iteration, the FSM enters FLUSH.
REQ-014 FLUSH SHALL wait for the final command to transfer, then go to FINISH. FINISH asserts done for one cycle, then returns to IDLE.
REQ-015 start SHALL be ignored while busy=1.
REQ-016 abort SHALL, in any state, force IDLE on the next edge: cmd_valid=0, pending cleared, no done pulse. abort wins over a simultaneous start.
REQ-017 rom_addr SHALL be 0 in IDLE.

Reset
REQ-018 When rst_n=0, the block SHALL asynchronously enter IDLE with cmd_valid=0, busy=0, done=0, rom_addr=0, all cmd_* payloads 0, and row, col, iter and pending cleared.
REQ-019 Reset mid-schedule SHALL discard all state; no done pulse follows.

Structure
REQ-020 A shared package SHALL hold the FSM state enum, a command struct (row, col, shift, last, iter), and the SKIP constant function of WIDTH.
REQ-021 The block SHALL instantiate no ROM; the proto-matrix ROM is connected externally. One sub-module, proto_cmd_reg (the valid/ready output register), is natural.

Verification
REQ-022 Z=54, num_iter=1, cmd_ready=1: commands SHALL match the non-skip entries of the ROM image in row-major order, each row's final entry carrying cmd_last=1, and done SHALL pulse once.
REQ-023 A stub ROM with all skips in row 2 SHALL produce no row-2 commands, and row 1 SHALL end with cmd_last=1.
REQ-024 Randomly toggled cmd_ready SHALL yield an identical command sequence, with payload stable during every stall.
REQ-025 num_iter=3 SHALL produce three identical passes with cmd_iter=0,1,2; num_iter=0 SHALL behave as one pass.
REQ-026 abort asserted mid-row-1 SHALL give cmd_valid=0 and busy=0 on the next cycle with no done; a following start SHALL restart from row 0, col 0.
REQ-027 Reset asserted while cmd_valid=1 and cmd_ready=0 SHALL clear all outputs immediately; start during busy SHALL have no effect.
